// File: rtl/reram_xbar_responder.sv
// rtl/reram_xbar_responder.sv - ReRAM crossbar column responder: dot product, ADC shift/saturate, one-shot result
module reram_xbar_responder #(
    parameter int ROWS         = 8,
    parameter int COLS         = 256,
    parameter int DAC_WIDTH    = 10,
    parameter int WEIGHT_WIDTH = 4,
    parameter int OUTPUT_WIDTH = 12,
    parameter int ADC_SHIFT    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DAC_WIDTH-1:0]      dac_in,
    input  logic                      dac_valid,
    input  logic                      drv_clear,
    input  logic                      xbar_enable,
    input  logic [9:0]                xbar_addr,
    output logic [OUTPUT_WIDTH-1:0]   xbar_data,
    output logic                      xbar_valid,
    output logic                      addr_err,
    output logic                      busy,
    input  logic                      prog_we,
    input  logic [$clog2(ROWS)-1:0]   prog_row,
    input  logic [$clog2(COLS)-1:0]   prog_col,
    input  logic [WEIGHT_WIDTH-1:0]   prog_wdata
);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int ACC_W = DAC_WIDTH + WEIGHT_WIDTH + RW;
    localparam int SH_W  = ACC_W - ADC_SHIFT;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [10:0]   COLS_LIM = 11'(COLS);

    typedef enum logic [1:0] {IDLE, ACCUM, CONVERT, RELEASE} state_t;

    state_t                  state;
    logic [ACC_W-1:0]        acc;
    logic [RW-1:0]           row;
    logic [CW-1:0]           col;
    logic                    col_oor;
    logic [RW-1:0]           wr_ptr;
    logic [DAC_WIDTH-1:0]    drive [ROWS];
    logic [WEIGHT_WIDTH-1:0] g_mem [ROWS][COLS];

    logic                    req_oor;
    logic [ACC_W-1:0]        term;
    logic [SH_W-1:0]         shifted;
    logic [OUTPUT_WIDTH-1:0] adc_out;
    logic                    drive_we;
    logic [RW-1:0]           wr_idx;
    logic                    g_we;

    assign req_oor  = {1'b0, xbar_addr} >= COLS_LIM;
    assign term     = ACC_W'(drive[row]) * ACC_W'(g_mem[row][col]);
    assign shifted  = SH_W'(acc >> ADC_SHIFT);
    assign adc_out  = (|shifted[SH_W-1:OUTPUT_WIDTH]) ? '1 : shifted[OUTPUT_WIDTH-1:0];

    // Drive values are frozen while the column is being accumulated.
    assign drive_we = dac_valid && (state != ACCUM);
    assign wr_idx   = drv_clear ? '0 : wr_ptr;
    assign g_we     = prog_we && (state != ACCUM) && (state != CONVERT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            xbar_data  <= '0;
            xbar_valid <= 1'b0;
            addr_err   <= 1'b0;
            busy       <= 1'b0;
            acc        <= '0;
            row        <= '0;
            col        <= '0;
            col_oor    <= 1'b0;
        end else begin
            xbar_valid <= 1'b0;
            addr_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (xbar_enable) begin
                        col     <= xbar_addr[CW-1:0];
                        col_oor <= req_oor;
                        acc     <= '0;
                        row     <= '0;
                        busy    <= 1'b1;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    // Out-of-range requests still walk every row so latency never changes.
                    if (!col_oor) begin
                        acc <= acc + term;
                    end
                    row <= row + 1'b1;
                    if (row == LAST_ROW) begin
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    xbar_data  <= adc_out;
                    xbar_valid <= 1'b1;
                    addr_err   <= col_oor;
                    busy       <= 1'b0;
                    state      <= RELEASE;
                end
                RELEASE: begin
                    // Wait out the controller's registered enable so one request yields one result.
                    if (!xbar_enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            for (int i = 0; i < ROWS; i++) begin
                drive[i] <= '0;
            end
        end else if (drive_we) begin
            drive[wr_idx] <= dac_in;
            wr_ptr        <= wr_idx + 1'b1;
        end else if (drv_clear) begin
            wr_ptr <= '0;
        end
    end

    // Conductance codes survive reset; they hold whatever was last programmed.
    always_ff @(posedge clk) begin
        if (g_we) begin
            g_mem[prog_row][prog_col] <= prog_wdata;
        end
    end

endmodule

// File: tb/tb_reram_xbar_responder.sv
// tb/tb_reram_xbar_responder.sv - directed and randomized bench for reram_xbar_responder against a behavioural model
module tb_reram_xbar_responder;
    localparam int ROWS  = 8;
    localparam int COLS  = 256;
    localparam int SHIFT = 4;
    localparam int OMAX  = 4095;
    localparam int LAT   = ROWS + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  dac_in;
    logic        dac_valid;
    logic        drv_clear;
    logic        xbar_enable;
    logic [9:0]  xbar_addr;
    logic [11:0] xbar_data;
    logic        xbar_valid;
    logic        addr_err;
    logic        busy;
    logic        prog_we;
    logic [2:0]  prog_row;
    logic [7:0]  prog_col;
    logic [3:0]  prog_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    reram_xbar_responder #(
        .ROWS(ROWS), .COLS(COLS), .DAC_WIDTH(10), .WEIGHT_WIDTH(4),
        .OUTPUT_WIDTH(12), .ADC_SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .dac_in(dac_in), .dac_valid(dac_valid),
        .drv_clear(drv_clear), .xbar_enable(xbar_enable), .xbar_addr(xbar_addr),
        .xbar_data(xbar_data), .xbar_valid(xbar_valid), .addr_err(addr_err),
        .busy(busy), .prog_we(prog_we), .prog_row(prog_row), .prog_col(prog_col),
        .prog_wdata(prog_wdata)
    );

    always #5 clk = ~clk;

    // Model state: array contents, drive ring, and edges elapsed since the accepted request.
    int          g_m [ROWS][COLS];
    int          drv_m [ROWS];
    int          m_wr;
    int          age;
    int          pend;
    bit          pend_err;
    bit          live;
    logic [14:0] exp_vec;

    function automatic int col_sum(input int a);
        int s = 0;
        if (a >= COLS) return 0;
        for (int r = 0; r < ROWS; r++) s += drv_m[r] * g_m[r][a];
        return s;
    endfunction

    function automatic int adc(input int s);
        int q = s >> SHIFT;
        return (q > OMAX) ? OMAX : q;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_vec(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got {valid,err,busy,data}=%h expected %h", name, $time, act, exp);
    endtask

    initial begin
        bit accum, conv;
        live = 0; age = 0; m_wr = 0; pend = 0; pend_err = 0; exp_vec = '0;
        for (int r = 0; r < ROWS; r++) begin
            drv_m[r] = 0;
            for (int c = 0; c < COLS; c++) g_m[r][c] = 0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                live = 1; age = 0; m_wr = 0; exp_vec = '0;
                for (int r = 0; r < ROWS; r++) drv_m[r] = 0;
            end else if (live) begin
                accum = (age >= 1) && (age <= ROWS);
                conv  = (age == ROWS + 1);
                if (prog_we && !accum && !conv)
                    g_m[int'(prog_row)][int'(prog_col)] = int'(prog_wdata);
                if (dac_valid && !accum) begin
                    if (drv_clear) m_wr = 0;
                    drv_m[m_wr] = int'(dac_in);
                    m_wr = (m_wr + 1) % ROWS;
                end else if (drv_clear) begin
                    m_wr = 0;
                end
                exp_vec[14] = 1'b0;
                exp_vec[13] = 1'b0;
                if (age == 0) begin
                    if (xbar_enable) begin
                        age      = 1;
                        pend     = col_sum(int'(xbar_addr));
                        pend_err = int'(xbar_addr) >= COLS;
                    end
                end else if (age <= ROWS) begin
                    age++;
                end else if (age == ROWS + 1) begin
                    age          = LAT;
                    exp_vec[14]  = 1'b1;
                    exp_vec[13]  = pend_err;
                    exp_vec[11:0] = 12'(adc(pend));
                end else if (!xbar_enable) begin
                    age = 0;
                end
                exp_vec[12] = (age >= 1) && (age <= ROWS + 1);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (live) check_vec("cycle", {xbar_valid, addr_err, busy, xbar_data}, exp_vec);
        end
    end

    task automatic prog(input int r, input int c, input int w);
        @(negedge clk);
        prog_we = 1'b1; prog_row = 3'(r); prog_col = 8'(c); prog_wdata = 4'(w);
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic dac(input int v, input bit clr);
        @(negedge clk);
        dac_valid = 1'b1; dac_in = 10'(v); drv_clear = clr;
        @(negedge clk);
        dac_valid = 1'b0; drv_clear = 1'b0;
    endtask

    // Cycle c counts negedges after the accepting edge; the result is expected at c = LAT.
    task automatic request(input int a, input int hold, input int dac_at, input int rst_at,
                           output int lat, output int nvalid, output int nbusy,
                           output logic [11:0] data, output logic err, output logic [14:0] post);
        @(negedge clk);
        xbar_enable = 1'b1; xbar_addr = 10'(a);
        lat = -1; nvalid = 0; nbusy = 0; data = '0; err = 1'b0; post = '1;
        for (int c = 1; c <= hold + 14; c++) begin
            @(negedge clk);
            if (c == rst_at + 1) post = {xbar_valid, addr_err, busy, xbar_data};
            dac_valid = 1'b0; rst = 1'b0;
            if (xbar_valid) begin
                nvalid++;
                if (lat < 0) begin lat = c; data = xbar_data; err = addr_err; end
            end
            if (busy) nbusy++;
            if (c >= hold) xbar_enable = 1'b0;
            if (c == dac_at) begin dac_valid = 1'b1; dac_in = 10'd999; end
            if (c == rst_at) rst = 1'b1;
        end
    endtask

    initial begin
        int lat, nv, nb;
        logic [11:0] d;
        logic e;
        logic [14:0] post;
        rst = 1'b1; dac_in = '0; dac_valid = 1'b0; drv_clear = 1'b0; xbar_enable = 1'b0;
        xbar_addr = '0; prog_we = 1'b0; prog_row = '0; prog_col = '0; prog_wdata = '0;
        repeat (3) @(negedge clk);
        check_vec("reset_outputs", {xbar_valid, addr_err, busy, xbar_data}, 15'h0);
        rst = 1'b0;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) prog(r, c, int'($urandom_range(0, 15)));

        // Normal read: 100 * (1+..+8) = 3600, >> 4 = 225
        for (int r = 0; r < ROWS; r++) prog(r, 3, r + 1);
        for (int i = 0; i < ROWS; i++) dac(100, i == 0);
        check("model_sum_col3", col_sum(3), 3600);
        request(3, 1, 0, 0, lat, nv, nb, d, e, post);
        check("normal_data", int'(d), 225);
        check("normal_latency", lat, LAT);
        check("normal_nvalid", nv, 1);
        check("normal_busy_cycles", nb, ROWS + 1);
        check("normal_err", int'(e), 0);

        // Saturation: 1023*15*8 = 122760, >> 4 = 7672 -> 4095
        for (int r = 0; r < ROWS; r++) prog(r, 5, 15);
        for (int i = 0; i < ROWS; i++) dac(1023, i == 0);
        check("model_sum_col5", col_sum(5), 122760);
        request(5, 1, 0, 0, lat, nv, nb, d, e, post);
        check("sat_data", int'(d), 4095);
        check("sat_err", int'(e), 0);
        check("sat_latency", lat, LAT);

        // Held enable: one result only, then a fresh request after enable drops
        for (int i = 0; i < ROWS; i++) dac(100, i == 0);
        request(3, 40, 0, 0, lat, nv, nb, d, e, post);
        check("held_nvalid", nv, 1);
        check("held_data", int'(d), 225);
        request(3, 1, 0, 0, lat, nv, nb, d, e, post);
        check("held_second_data", int'(d), 225);
        check("held_second_nvalid", nv, 1);

        request(300, 1, 0, 0, lat, nv, nb, d, e, post);
        check("oor_data", int'(d), 0);
        check("oor_err", int'(e), 1);
        check("oor_latency", lat, LAT);

        // Ring wrap: 18 overwrites row 0, rows 1..7 hold 11..17 -> 116, >> 4 = 7
        for (int r = 0; r < ROWS; r++) prog(r, 0, 1);
        dac(10, 1'b1);
        for (int v = 11; v <= 18; v++) dac(v, 1'b0);
        check("model_sum_ring", col_sum(0), 116);
        request(0, 1, 0, 0, lat, nv, nb, d, e, post);
        check("ring_data", int'(d), 7);
        request(0, 1, 3, 0, lat, nv, nb, d, e, post);
        check("freeze_data", int'(d), 7);
        // Ignored strobe must not advance the pointer: next write lands on row 1 (11 -> 50)
        dac(50, 1'b0);
        request(0, 1, 0, 0, lat, nv, nb, d, e, post);
        check("freeze_ptr_data", int'(d), 9);

        request(3, 1, 0, 4, lat, nv, nb, d, e, post);
        check("rst_mid_nvalid", nv, 0);
        check("rst_mid_outputs", int'(post), 0);
        for (int i = 0; i < ROWS; i++) dac(100, i == 0);
        request(3, 1, 0, 0, lat, nv, nb, d, e, post);
        check("rst_recover_data", int'(d), 225);
        check("rst_recover_latency", lat, LAT);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 299) == 0);
            prog_we     = ($urandom_range(0, 3) == 0);
            prog_row    = 3'($urandom);
            prog_col    = 8'($urandom);
            prog_wdata  = 4'($urandom);
            dac_valid   = ($urandom_range(0, 2) == 0);
            dac_in      = 10'($urandom);
            drv_clear   = ($urandom_range(0, 15) == 0);
            xbar_enable = ($urandom_range(0, 2) != 0);
            xbar_addr   = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(256, 1023))
                                                      : 10'($urandom_range(0, 255));
        end
        @(negedge clk);
        rst = 1'b0; prog_we = 1'b0; dac_valid = 1'b0; drv_clear = 1'b0; xbar_enable = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
